// File: rtl/alu_pair_dispatch.sv
// Dual-ALU issue stage: registers up to two decoded ops per cycle onto lanes 0/1,
// bypassing lane0's result into lane1 or splitting a dependent pair over two cycles.
module alu_pair_dispatch #(
  parameter int XLEN     = 64,
  parameter int OpW      = 8,
  parameter int TransIdW = 3,
  parameter bit BypassEn = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [1:0]                    issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [1:0][OpW-1:0]           op_i,
  input  logic [1:0][4:0]               rs1_i,
  input  logic [1:0][4:0]               rs2_i,
  input  logic [1:0][4:0]               rd_i,
  input  logic [1:0]                    rd_we_i,
  input  logic [1:0]                    nobyp_i,
  input  logic [1:0][XLEN-1:0]          opa_i,
  input  logic [1:0][XLEN-1:0]          opb_i,
  input  logic [1:0][TransIdW-1:0]      trans_id_i,
  input  logic [XLEN-1:0]               alu_result0_i,
  output logic [1:0]                    alu_valid_o,
  output logic [1:0][OpW-1:0]           alu_op_o,
  output logic [1:0][XLEN-1:0]          alu_opa_o,
  output logic [1:0][XLEN-1:0]          alu_opb_o,
  output logic [1:0][TransIdW-1:0]      alu_trans_id_o,
  output logic                          rs1_from_rd_o,
  output logic                          rs2_from_rd_o
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t state_q, state_d;

  logic [1:0]               valid_q, valid_d;
  logic [1:0][OpW-1:0]      op_q, op_d;
  logic [1:0][XLEN-1:0]     opa_q, opa_d;
  logic [1:0][XLEN-1:0]     opb_q, opb_d;
  logic [1:0][TransIdW-1:0] tid_q, tid_d;
  logic                     rs1_byp_q, rs1_byp_d;
  logic                     rs2_byp_q, rs2_byp_d;

  logic                     hold_valid_q, hold_valid_d;
  logic [OpW-1:0]           hold_op_q, hold_op_d;
  logic [XLEN-1:0]          hold_opa_q, hold_opa_d;
  logic [XLEN-1:0]          hold_opb_q, hold_opb_d;
  logic [TransIdW-1:0]      hold_tid_q, hold_tid_d;
  logic                     hold_depa_q, hold_depa_d;
  logic                     hold_depb_q, hold_depb_d;

  logic dep_a, dep_b, dep, byp, accept;

  // Only slot0's bypassability matters: slot1 never feeds anything in this pair.
  logic unused_nobyp1;
  assign unused_nobyp1 = nobyp_i[1];

  assign dep_a  = issue_valid_i[1] && rd_we_i[0] && (rd_i[0] != 5'd0) && (rs1_i[1] == rd_i[0]);
  assign dep_b  = issue_valid_i[1] && rd_we_i[0] && (rd_i[0] != 5'd0) && (rs2_i[1] == rd_i[0]);
  assign dep    = dep_a || dep_b;
  assign byp    = dep && (BypassEn != 1'b0) && !nobyp_i[0];
  assign accept = (state_q == IDLE) && issue_valid_i[0];

  assign issue_ready_o = (state_q == IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept && dep && !byp) state_d = HOLD;
        HOLD:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d      = 2'b00;
    op_d         = op_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    tid_d        = tid_q;
    rs1_byp_d    = 1'b0;
    rs2_byp_d    = 1'b0;
    hold_valid_d = hold_valid_q;
    hold_op_d    = hold_op_q;
    hold_opa_d   = hold_opa_q;
    hold_opb_d   = hold_opb_q;
    hold_tid_d   = hold_tid_q;
    hold_depa_d  = hold_depa_q;
    hold_depb_d  = hold_depb_q;

    if (flush_i) begin
      hold_valid_d = 1'b0;
    end else if (state_q == HOLD) begin
      // Held op always drains on lane0, with its stale operand replaced by lane0's result.
      hold_valid_d = 1'b0;
      valid_d      = {1'b0, hold_valid_q};
      op_d[0]      = hold_op_q;
      opa_d[0]     = hold_depa_q ? alu_result0_i : hold_opa_q;
      opb_d[0]     = hold_depb_q ? alu_result0_i : hold_opb_q;
      tid_d[0]     = hold_tid_q;
    end else if (accept) begin
      valid_d[0] = 1'b1;
      op_d[0]    = op_i[0];
      opa_d[0]   = opa_i[0];
      opb_d[0]   = opb_i[0];
      tid_d[0]   = trans_id_i[0];
      if (dep && !byp) begin
        hold_valid_d = 1'b1;
        hold_op_d    = op_i[1];
        hold_opa_d   = opa_i[1];
        hold_opb_d   = opb_i[1];
        hold_tid_d   = trans_id_i[1];
        hold_depa_d  = dep_a;
        hold_depb_d  = dep_b;
      end else if (issue_valid_i[1]) begin
        valid_d[1] = 1'b1;
        op_d[1]    = op_i[1];
        opa_d[1]   = opa_i[1];
        opb_d[1]   = opb_i[1];
        tid_d[1]   = trans_id_i[1];
        rs1_byp_d  = byp && dep_a;
        rs2_byp_d  = byp && dep_b;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      op_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      tid_q        <= '0;
      rs1_byp_q    <= 1'b0;
      rs2_byp_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_op_q    <= '0;
      hold_opa_q   <= '0;
      hold_opb_q   <= '0;
      hold_tid_q   <= '0;
      hold_depa_q  <= 1'b0;
      hold_depb_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      op_q         <= op_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      tid_q        <= tid_d;
      rs1_byp_q    <= rs1_byp_d;
      rs2_byp_q    <= rs2_byp_d;
      hold_valid_q <= hold_valid_d;
      hold_op_q    <= hold_op_d;
      hold_opa_q   <= hold_opa_d;
      hold_opb_q   <= hold_opb_d;
      hold_tid_q   <= hold_tid_d;
      hold_depa_q  <= hold_depa_d;
      hold_depb_q  <= hold_depb_d;
    end
  end

  assign alu_valid_o    = valid_q;
  assign alu_op_o       = op_q;
  assign alu_opa_o      = opa_q;
  assign alu_opb_o      = opb_q;
  assign alu_trans_id_o = tid_q;
  assign rs1_from_rd_o  = rs1_byp_q;
  assign rs2_from_rd_o  = rs2_byp_q;

endmodule

// File: tb/tb_alu_pair_dispatch.sv
// Bench for alu_pair_dispatch: one instance with bypass enabled, one without, both
// driven identically and compared against a pair-level reference model.
module tb_alu_pair_dispatch;

  localparam int XLEN = 64;
  localparam int OpW  = 8;
  localparam int TW   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, flush;
  logic [1:0]             iv, we, nb;
  logic [1:0][OpW-1:0]    op;
  logic [1:0][4:0]        rs1, rs2, rd;
  logic [1:0][XLEN-1:0]   opa, opb;
  logic [1:0][TW-1:0]     tid;
  logic [XLEN-1:0]        res;

  logic                   ready_o [2];
  logic [1:0]             valid_o [2];
  logic [1:0][OpW-1:0]    op_o    [2];
  logic [1:0][XLEN-1:0]   opa_o   [2];
  logic [1:0][XLEN-1:0]   opb_o   [2];
  logic [1:0][TW-1:0]     tid_o   [2];
  logic                   f1_o    [2];
  logic                   f2_o    [2];

  alu_pair_dispatch #(.XLEN(XLEN), .OpW(OpW), .TransIdW(TW), .BypassEn(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .issue_valid_i(iv), .issue_ready_o(ready_o[0]),
    .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .rd_we_i(we), .nobyp_i(nb),
    .opa_i(opa), .opb_i(opb), .trans_id_i(tid), .alu_result0_i(res),
    .alu_valid_o(valid_o[0]), .alu_op_o(op_o[0]), .alu_opa_o(opa_o[0]), .alu_opb_o(opb_o[0]),
    .alu_trans_id_o(tid_o[0]), .rs1_from_rd_o(f1_o[0]), .rs2_from_rd_o(f2_o[0]));

  alu_pair_dispatch #(.XLEN(XLEN), .OpW(OpW), .TransIdW(TW), .BypassEn(1'b0)) dut_n (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .issue_valid_i(iv), .issue_ready_o(ready_o[1]),
    .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .rd_we_i(we), .nobyp_i(nb),
    .opa_i(opa), .opb_i(opb), .trans_id_i(tid), .alu_result0_i(res),
    .alu_valid_o(valid_o[1]), .alu_op_o(op_o[1]), .alu_opa_o(opa_o[1]), .alu_opb_o(opb_o[1]),
    .alu_trans_id_o(tid_o[1]), .rs1_from_rd_o(f1_o[1]), .rs2_from_rd_o(f2_o[1]));

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what each lane should show, plus the op parked by a split pair.
  typedef struct {
    logic [OpW-1:0]  op;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [TW-1:0]   tid;
  } lane_t;

  lane_t      e_lane [2][2];
  logic [1:0] e_valid [2];
  logic       e_f1 [2], e_f2 [2];
  lane_t      h_lane [2];
  bit         h_pa [2], h_pb [2], h_have [2];

  function automatic lane_t slot_of(input int s);
    lane_t l;
    l.op = op[s]; l.opa = opa[s]; l.opb = opb[s]; l.tid = tid[s];
    return l;
  endfunction

  task automatic model_reset();
    lane_t z;
    z.op = '0; z.opa = '0; z.opb = '0; z.tid = '0;
    for (int k = 0; k < 2; k++) begin
      e_lane[k][0] = z; e_lane[k][1] = z;
      e_valid[k] = 2'b00; e_f1[k] = 1'b0; e_f2[k] = 1'b0; h_have[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit byp_en);
    bit writes, ra, rb;
    e_f1[k] = 1'b0;
    e_f2[k] = 1'b0;
    if (flush) begin
      e_valid[k] = 2'b00;
      h_have[k]  = 1'b0;
    end else if (h_have[k]) begin
      e_lane[k][0] = h_lane[k];
      if (h_pa[k]) e_lane[k][0].opa = res;
      if (h_pb[k]) e_lane[k][0].opb = res;
      e_valid[k] = 2'b01;
      h_have[k]  = 1'b0;
    end else if (iv[0]) begin
      writes = we[0] && (rd[0] != 0);
      ra = iv[1] && writes && (rs1[1] == rd[0]);
      rb = iv[1] && writes && (rs2[1] == rd[0]);
      e_lane[k][0] = slot_of(0);
      if ((ra || rb) && (!byp_en || nb[0])) begin
        h_lane[k] = slot_of(1); h_pa[k] = ra; h_pb[k] = rb; h_have[k] = 1'b1;
        e_valid[k] = 2'b01;
      end else begin
        e_valid[k] = {iv[1], 1'b1};
        if (iv[1]) e_lane[k][1] = slot_of(1);
        e_f1[k] = ra;
        e_f2[k] = rb;
      end
    end else begin
      e_valid[k] = 2'b00;
    end
  endtask

  task automatic compare_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("valid%0d", k), valid_o[k], e_valid[k]);
      check($sformatf("rs1byp%0d", k), f1_o[k], e_f1[k]);
      check($sformatf("rs2byp%0d", k), f2_o[k], e_f2[k]);
      for (int l = 0; l < 2; l++) begin
        if (e_valid[k][l]) begin
          check($sformatf("op%0d_l%0d", k, l), op_o[k][l], e_lane[k][l].op);
          check($sformatf("opa%0d_l%0d", k, l), opa_o[k][l], e_lane[k][l].opa);
          check($sformatf("opb%0d_l%0d", k, l), opb_o[k][l], e_lane[k][l].opb);
          check($sformatf("tid%0d_l%0d", k, l), tid_o[k][l], e_lane[k][l].tid);
        end
      end
    end
  endtask

  // One clock: inputs already driven; sample outputs 1 time unit after the edge.
  task automatic cycle();
    for (int k = 0; k < 2; k++) check($sformatf("ready%0d", k), ready_o[k], !h_have[k]);
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    #1;
    compare_outputs();
    $display("[TB] t=%0t iv=%b flush=%b valid=%b/%b byp=%b%b", $time, iv, flush,
             valid_o[0], valid_o[1], f1_o[0], f2_o[0]);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    iv = 2'b00; flush = 1'b0; we = 2'b00; nb = 2'b00;
    op = '0; rs1 = '0; rs2 = '0; rd = '0; opa = '0; opb = '0; tid = '0; res = '0;
  endtask

  task automatic set_slot(input int s, input logic [OpW-1:0] o, input logic [4:0] a,
                          input logic [4:0] b, input logic [4:0] d, input logic w,
                          input logic n, input logic [XLEN-1:0] va, input logic [XLEN-1:0] vb,
                          input logic [TW-1:0] t);
    op[s] = o; rs1[s] = a; rs2[s] = b; rd[s] = d; we[s] = w; nb[s] = n;
    opa[s] = va; opb[s] = vb; tid[s] = t;
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_valid%0d", tag, k), valid_o[k], 2'b00);
      check($sformatf("%s_ready%0d", tag, k), ready_o[k], 1'b1);
      check($sformatf("%s_flags%0d", tag, k), {f1_o[k], f2_o[k]}, 2'b00);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    check("rst_op", op_o[0], '0);
    check("rst_opa", opa_o[0], '0);
    check("rst_tid", tid_o[1], '0);
    @(negedge clk);
    rst = 1'b0;

    // Independent pair.
    iv = 2'b11;
    set_slot(0, 8'h01, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 64'h11, 64'h22, 3'd1);
    set_slot(1, 8'h02, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0, 64'h33, 64'h44, 3'd2);
    cycle();
    check("indep_valid", valid_o[0], 2'b11);

    // Bypassable RAW on both sources.
    set_slot(1, 8'h02, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 64'h55, 64'h66, 3'd3);
    cycle();
    check("byp_flags", {f1_o[0], f2_o[0]}, 2'b11);
    check("nobypen_split", valid_o[1], 2'b01);
    iv = 2'b00; res = 64'h1234;
    cycle();
    check("nobypen_opa", opa_o[1][0], 64'h1234);

    // Non-bypassable producer forces a split; second slot drains with patched opb.
    iv = 2'b11;
    set_slot(0, 8'h30, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 64'h7, 64'h8, 3'd4);
    set_slot(1, 8'h01, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0, 64'h9, 64'hDEAD, 3'd5);
    cycle();
    check("split_ready", ready_o[0], 1'b0);
    iv = 2'b11; res = 64'h21;
    cycle();
    check("split_opb", opb_o[0][0], 64'h21);
    check("split_tid", tid_o[0][0], 3'd5);
    check("split_ready_back", ready_o[0], 1'b1);

    // x0 destination and non-writing producer never create a dependence.
    iv = 2'b11;
    set_slot(0, 8'h01, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 64'h1, 64'h2, 3'd6);
    set_slot(1, 8'h01, 5'd0, 5'd4, 5'd7, 1'b1, 1'b0, 64'h3, 64'h4, 3'd7);
    cycle();
    set_slot(0, 8'h01, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 64'h1, 64'h2, 3'd6);
    set_slot(1, 8'h01, 5'd3, 5'd3, 5'd7, 1'b1, 1'b0, 64'h3, 64'h4, 3'd7);
    cycle();
    check("nowe_valid_n", valid_o[1], 2'b11);

    // Flush while holding.
    set_slot(0, 8'h30, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 64'h7, 64'h8, 3'd1);
    set_slot(1, 8'h01, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0, 64'h9, 64'hDEAD, 3'd2);
    cycle();
    flush = 1'b1; iv = 2'b11;
    cycle();
    check("flush_valid", valid_o[0], 2'b00);
    flush = 1'b0; iv = 2'b00;
    cycle();

    // Asynchronous reset while holding drops the parked op at once.
    iv = 2'b11;
    set_slot(0, 8'h30, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 64'h7, 64'h8, 3'd1);
    set_slot(1, 8'h01, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 64'h9, 64'hA, 3'd2);
    cycle();
    idle_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_state("arst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Randomized traffic with narrow register indices to provoke dependences.
    for (int n = 0; n < 400; n++) begin
      iv    = 2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 15) == 0);
      res   = {$urandom, $urandom};
      for (int s = 0; s < 2; s++) begin
        set_slot(s, 8'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) == 0),
                 {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom));
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
